// File: rtl/fp_mac_pack_out.sv
// fp_mac_pack_out: output stage of the FP16 MAC pipeline.
// Stage 1 normalizes the raw significand; stage 2 rounds to nearest-even,
// handles overflow/underflow and packs an IEEE-754 half word.
// Optional feature macro: FP_MAC_FLAGS_EN adds out_flags = {overflow, underflow, inexact}.
// The output bias (15) is implicit: a significand with its leading one at
// bit 20 and in_exponent = e packs directly to biased exponent e.
module fp_mac_pack_out (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exponent,
    input  logic [21:0] in_significand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result
`ifdef FP_MAC_FLAGS_EN
    ,
    output logic [2:0]  out_flags
`endif
);

    localparam int unsigned SIG_W  = 22;
    localparam int unsigned MAN_W  = 10;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned LEAD_W = 5;
    localparam int unsigned E_W    = 9;
    localparam int unsigned ER_W   = 10;

    // Stage 1 registers
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_sign_q,  s1_sign_d;
    logic                    s1_zero_q,  s1_zero_d;
    logic signed [E_W-1:0]   s1_exp_q,   s1_exp_d;
    logic [SIG_W-2:0]        s1_sig_q,   s1_sig_d;

    // Output registers
    logic                    out_valid_q, out_valid_d;
    logic [15:0]             out_result_q, out_result_d;

    // Handshake
    logic                    s1_adv;
    logic                    in_fire;

    // Normalizer internals
    logic [LEAD_W-1:0]       lead_p;
    logic [LEAD_W-1:0]       shamt;
    logic [SIG_W-1:0]        norm;

    // Rounder internals
    logic [MAN_W-1:0]        man_raw;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [MAN_W:0]          man_sum;
    logic signed [ER_W-1:0]  e_rnd;
    logic                    ovf;
    logic                    unf;

    // Stage 1 drains into the output register whenever that register is free or draining
    always_comb begin
        s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s1_adv;
        in_fire  = in_valid && in_ready;
    end

    // Normalize: find leading one, shift it to bit 21, rebase exponent
    always_comb begin
        lead_p = '0;
        for (int i = 0; i < int'(SIG_W); i++) begin
            if (in_significand[i]) begin
                lead_p = LEAD_W'(i);
            end
        end
        shamt      = LEAD_W'(SIG_W - 1) - lead_p;
        norm       = in_significand << shamt;
        s1_sign_d  = in_sign;
        s1_zero_d  = ~norm[SIG_W-1];
        s1_sig_d   = norm[SIG_W-2:0];
        s1_exp_d   = E_W'(in_exponent) + E_W'(lead_p) - E_W'(SIG_W - 2);
        s1_valid_d = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    end

    // Stage 1 register: payload loads only on an accepted input
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_sig_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_exp_q  <= s1_exp_d;
                s1_sig_q  <= s1_sig_d;
            end
        end
    end

    // Round to nearest-even and classify the rounded exponent
    always_comb begin
        man_raw  = s1_sig_q[SIG_W-2:SIG_W-1-MAN_W];
        guard    = s1_sig_q[SIG_W-2-MAN_W];
        sticky   = |s1_sig_q[SIG_W-3-MAN_W:0];
        round_up = guard && (sticky || man_raw[0]);
        man_sum  = {1'b0, man_raw} + (MAN_W+1)'(round_up);
        e_rnd    = {s1_exp_q[E_W-1], s1_exp_q} + ER_W'(man_sum[MAN_W]);
        ovf      = !s1_zero_q && (e_rnd >= 10'sd31);
        unf      = !s1_zero_q && (e_rnd <= 10'sd0);
    end

    // Pack the half word
    always_comb begin
        out_result_d = {s1_sign_q, 15'h0000};
        if (s1_zero_q || unf) begin
            out_result_d = {s1_sign_q, 15'h0000};
        end else if (ovf) begin
            out_result_d = {s1_sign_q, 5'h1F, 10'h000};
        end else begin
            out_result_d = {s1_sign_q, e_rnd[EXP_W-1:0], man_sum[MAN_W-1:0]};
        end
        out_valid_d = s1_adv || (out_valid_q && !out_ready);
    end

    // Output register: holds while the consumer stalls
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_adv) begin
                out_result_q <= out_result_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

`ifdef FP_MAC_FLAGS_EN
    logic [2:0] flags_q, flags_d;

    // Exception flags travel with the packed word
    always_comb begin
        flags_d = {ovf, unf, !s1_zero_q && (guard || sticky || ovf || unf)};
    end

    // Flag register loads alongside out_result
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flags_q <= '0;
        end else if (s1_adv) begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`endif

endmodule
